// File: rtl/uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// uart_cmd_framer
//
// Framing layer between a byte-level UART and a command processor.
//  - RX: assembles CMD_BYTES received bytes (first byte in the MSBs) into one
//    command word. A partial frame is discarded when the gap between bytes
//    runs past TIMEOUT_CYC cycles (0 disables the timeout).
//  - TX: serialises a RESP_BYTES-wide response, MSB byte first, into
//    consecutive UART transmits.
//  The RX and TX paths share no state.
//
// Handshakes:
//  rx_rdy/clr_rx_rdy : rx_rdy is the UART's level "byte valid". The byte is
//    consumed in every cycle rx_rdy=1, and clr_rx_rdy answers in that same
//    cycle, so reception never stalls.
//  cmd_rdy/clr_cmd_rdy : cmd_rdy is a level valid and cmd is stable while it
//    is high. clr_cmd_rdy acknowledges it; a frame completing in the same
//    cycle wins and keeps cmd_rdy high with the new cmd.
//  trmt/tx_busy : trmt is accepted only while tx_busy=0 and is otherwise
//    ignored.
//  uart_trmt/uart_tx_done : uart_trmt is a 1-cycle start pulse. uart_tx_done
//    is a level that the UART clears after the start pulse and sets again at
//    the end of the stop bit.
//
// Ports:
//  clk, rst_n                  clock, async active-low reset
//  rx_rdy, rx_data, clr_rx_rdy UART receive side
//  uart_trmt, uart_tx_data,
//  uart_tx_done                UART transmit side
//  cmd, cmd_rdy, clr_cmd_rdy   assembled command to the consumer
//  cmd_ovr                     pulse: frame completed over an unacked cmd
//  frame_err                   pulse: partial frame dropped on timeout
//  trmt, resp                  response request from the command processor
//  tx_busy, tx_done            response serialisation status
//  rx_state_dbg, tx_state_dbg  current FSM states, for observation
// ---------------------------------------------------------------------------
module uart_cmd_framer #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic                    uart_trmt,
  output logic [7:0]              uart_tx_data,
  input  logic                    uart_tx_done,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    cmd_ovr,
  output logic                    frame_err,
  input  logic                    trmt,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    rx_state_dbg,
  output logic [1:0]              tx_state_dbg
);

  localparam int CW  = 8 * CMD_BYTES;
  localparam int RW  = 8 * RESP_BYTES;
  localparam int BCW = $clog2(CMD_BYTES + 1);
  localparam int TCW = $clog2(RESP_BYTES + 1);
  localparam int TMW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(CMD_BYTES - 1);
  localparam logic [TCW-1:0] RESP_LAST = TCW'(RESP_BYTES - 1);
  localparam logic [TMW-1:0] TMO_LIMIT = TMW'(TIMEOUT_CYC);

  typedef enum logic {R_IDLE, R_COLLECT} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP, T_WAIT} tx_state_t;

  rx_state_t      rx_state;
  tx_state_t      tx_state;

  logic [CW-1:0]  shadow;
  logic [BCW-1:0] byte_cnt;
  logic [TMW-1:0] tmo_cnt;

  logic           tmo_hit;
  logic [CW-1:0]  base_shadow;
  logic [BCW-1:0] base_cnt;
  logic [CW-1:0]  shadow_nxt;
  logic           frame_done;

  logic [RW-1:0]  resp_sr;
  logic [RW-1:0]  resp_shift;
  logic [TCW-1:0] tx_left;

  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

  // Gated by rst_n so that every output reads 0 while reset is held.
  assign clr_rx_rdy = rx_rdy & rst_n;

  // tmo_cnt holds the idle cycles since the last accepted byte. When it
  // reaches the limit, the current cycle is the timeout cycle. A byte arriving
  // in that cycle starts a new frame, so the shift and count work from a
  // cleared base instead of the stale partial frame.
  always_comb begin
    tmo_hit     = (TIMEOUT_CYC != 0) && (rx_state == R_COLLECT) &&
                  (tmo_cnt == TMO_LIMIT);
    base_shadow = tmo_hit ? '0 : shadow;
    base_cnt    = tmo_hit ? '0 : byte_cnt;
    shadow_nxt  = base_shadow << 8;
    shadow_nxt[7:0] = rx_data;
    frame_done  = rx_rdy && (base_cnt == LAST_BYTE);
  end

  // RX FSM: collect bytes, publish cmd and drop timed-out partial frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= R_IDLE;
      shadow    <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      cmd_ovr   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_ovr   <= 1'b0;
      frame_err <= tmo_hit;

      if (rx_rdy) begin
        tmo_cnt <= '0;
        if (frame_done) begin
          cmd      <= shadow_nxt;
          shadow   <= '0;
          byte_cnt <= '0;
          rx_state <= R_IDLE;
        end else begin
          shadow   <= shadow_nxt;
          byte_cnt <= base_cnt + BCW'(1);
          rx_state <= R_COLLECT;
        end
      end else if (tmo_hit) begin
        shadow   <= '0;
        byte_cnt <= '0;
        tmo_cnt  <= '0;
        rx_state <= R_IDLE;
      end else if (rx_state == R_COLLECT && TIMEOUT_CYC != 0) begin
        tmo_cnt <= tmo_cnt + TMW'(1);
      end

      // A completing frame takes priority over the acknowledge. Overrun is
      // flagged only when the old cmd was neither acked nor being acked.
      if (frame_done) begin
        cmd_rdy <= 1'b1;
        cmd_ovr <= cmd_rdy & ~clr_cmd_rdy;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  always_comb begin
    resp_shift = resp_sr << 8;
  end

  // TX FSM: one byte goes out per SEND. In GAP, uart_tx_done is ignored
  // because the UART may not have cleared it yet after the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= T_IDLE;
      resp_sr      <= '0;
      tx_left      <= '0;
      uart_trmt    <= 1'b0;
      uart_tx_data <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      uart_trmt <= 1'b0;
      tx_done   <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (trmt) begin
            resp_sr      <= resp;
            tx_left      <= RESP_LAST;
            uart_tx_data <= resp[RW-1 -: 8];
            uart_trmt    <= 1'b1;
            tx_busy      <= 1'b1;
            tx_state     <= T_SEND;
          end
        end
        T_SEND: tx_state <= T_GAP;
        T_GAP:  tx_state <= T_WAIT;
        T_WAIT: begin
          if (uart_tx_done) begin
            if (tx_left != '0) begin
              resp_sr      <= resp_shift;
              uart_tx_data <= resp_shift[RW-1 -: 8];
              tx_left      <= tx_left - TCW'(1);
              uart_trmt    <= 1'b1;
              tx_state     <= T_SEND;
            end else begin
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              tx_state <= T_IDLE;
            end
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_framer
//
// Testbench for uart_cmd_framer. It uses two instances:
//  dut_a : CMD_BYTES=2, RESP_BYTES=2, default timeout (command and response paths)
//  dut_b : CMD_BYTES=3, RESP_BYTES=1, TIMEOUT_CYC=100 (frame timeout)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_framer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut_a signals ----------------
  logic        rx_rdy_a = 1'b0;
  logic [7:0]  rx_data_a = '0;
  logic        clr_rx_rdy_a;
  logic        uart_trmt_a;
  logic [7:0]  uart_tx_data_a;
  logic        uart_tx_done_a = 1'b1;
  logic [15:0] cmd_a;
  logic        cmd_rdy_a;
  logic        clr_cmd_rdy_a = 1'b0;
  logic        cmd_ovr_a;
  logic        frame_err_a;
  logic        trmt_a = 1'b0;
  logic [15:0] resp_a = '0;
  logic        tx_busy_a;
  logic        tx_done_a;
  logic        rx_dbg_a;
  logic [1:0]  tx_dbg_a;

  // ---------------- dut_b signals ----------------
  logic        rx_rdy_b = 1'b0;
  logic [7:0]  rx_data_b = '0;
  logic        clr_rx_rdy_b;
  logic        uart_trmt_b;
  logic [7:0]  uart_tx_data_b;
  logic        uart_tx_done_b = 1'b1;
  logic [23:0] cmd_b;
  logic        cmd_rdy_b;
  logic        clr_cmd_rdy_b = 1'b0;
  logic        cmd_ovr_b;
  logic        frame_err_b;
  logic        trmt_b = 1'b0;
  logic [7:0]  resp_b = '0;
  logic        tx_busy_b;
  logic        tx_done_b;
  logic        rx_dbg_b;
  logic [1:0]  tx_dbg_b;

  uart_cmd_framer #(.CMD_BYTES(2), .RESP_BYTES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy_a), .rx_data(rx_data_a), .clr_rx_rdy(clr_rx_rdy_a),
    .uart_trmt(uart_trmt_a), .uart_tx_data(uart_tx_data_a),
    .uart_tx_done(uart_tx_done_a),
    .cmd(cmd_a), .cmd_rdy(cmd_rdy_a), .clr_cmd_rdy(clr_cmd_rdy_a),
    .cmd_ovr(cmd_ovr_a), .frame_err(frame_err_a),
    .trmt(trmt_a), .resp(resp_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a),
    .rx_state_dbg(rx_dbg_a), .tx_state_dbg(tx_dbg_a)
  );

  uart_cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(1), .TIMEOUT_CYC(100)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rx_rdy(rx_rdy_b), .rx_data(rx_data_b), .clr_rx_rdy(clr_rx_rdy_b),
    .uart_trmt(uart_trmt_b), .uart_tx_data(uart_tx_data_b),
    .uart_tx_done(uart_tx_done_b),
    .cmd(cmd_b), .cmd_rdy(cmd_rdy_b), .clr_cmd_rdy(clr_cmd_rdy_b),
    .cmd_ovr(cmd_ovr_b), .frame_err(frame_err_b),
    .trmt(trmt_b), .resp(resp_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b),
    .rx_state_dbg(rx_dbg_b), .tx_state_dbg(tx_dbg_b)
  );

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  int n_clr_a    = 0;
  int n_trmt_a   = 0;
  int n_txdone_a = 0;
  int n_ferr_b   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (clr_rx_rdy_a) n_clr_a++;
    if (frame_err_b)  n_ferr_b++;
    if (tx_done_a)    n_txdone_a++;
    if (uart_trmt_a) begin
      n_trmt_a++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL uart_trmt_a_unexpected: got byte %0h expected no transmit",
                 uart_tx_data_a);
      end else begin
        check("uart_tx_data_a", {24'd0, uart_tx_data_a}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // UART transmitter model: drops uart_tx_done on the start pulse and raises
  // it again after a fixed frame time.
  int busy_a = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_a = 0;
      uart_tx_done_a = 1'b1;
    end else if (uart_trmt_a) begin
      busy_a = 20;
      uart_tx_done_a = 1'b0;
    end else if (busy_a > 0) begin
      busy_a--;
      if (busy_a == 0) uart_tx_done_a = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte_a(input logic [7:0] b, input logic ack);
    rx_rdy_a = 1'b1;
    rx_data_a = b;
    clr_cmd_rdy_a = ack;
    #1;
    check("clr_rx_rdy_a", {31'd0, clr_rx_rdy_a}, 32'd1);
    @(posedge clk);
    #1;
    rx_rdy_a = 1'b0;
    clr_cmd_rdy_a = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b);
    rx_rdy_b = 1'b1;
    rx_data_b = b;
    tick();
    rx_rdy_b = 1'b0;
  endtask

  task automatic wait_tx_done_a(input int start_cnt);
    for (int c = 0; c < 500 && n_txdone_a == start_cnt; c++) tick();
    check("tx_done_a_within_budget", n_txdone_a, start_cnt + 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        ack_first;  // acknowledge cmd_rdy before the frame
    logic        ack_done;   // acknowledge in the completion cycle
    logic [15:0] exp_cmd;
    logic        exp_ovr;
  } rx_vec_t;

  rx_vec_t vecs[5];

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int trmt_before;

    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 16'hA53C, 1'b0};
    vecs[1] = '{8'hBE, 8'hEF, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 1'b1, 1'b0, 16'h1234, 1'b0};
    vecs[3] = '{8'h56, 8'h78, 1'b0, 1'b1, 16'h5678, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 16'h00FF, 1'b0};

    // ---- reset state ----
    repeat (3) tick();
    check("rst_cmd_a", {16'd0, cmd_a}, 32'd0);
    check("rst_cmd_rdy_a", {31'd0, cmd_rdy_a}, 32'd0);
    check("rst_uart_trmt_a", {31'd0, uart_trmt_a}, 32'd0);
    check("rst_uart_tx_data_a", {24'd0, uart_tx_data_a}, 32'd0);
    check("rst_tx_busy_a", {31'd0, tx_busy_a}, 32'd0);
    check("rst_tx_done_a", {31'd0, tx_done_a}, 32'd0);
    check("rst_cmd_ovr_a", {31'd0, cmd_ovr_a}, 32'd0);
    check("rst_frame_err_b", {31'd0, frame_err_b}, 32'd0);
    check("rst_cmd_b", {8'd0, cmd_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ---- table-driven command frames on dut_a ----
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].ack_first) begin
        clr_cmd_rdy_a = 1'b1;
        tick();
        clr_cmd_rdy_a = 1'b0;
        check($sformatf("v%0d_ack_clears_cmd_rdy", i), {31'd0, cmd_rdy_a}, 32'd0);
      end
      send_byte_a(vecs[i].b0, 1'b0);
      send_byte_a(vecs[i].b1, vecs[i].ack_done);
      check($sformatf("v%0d_cmd", i), {16'd0, cmd_a}, {16'd0, vecs[i].exp_cmd});
      check($sformatf("v%0d_cmd_rdy", i), {31'd0, cmd_rdy_a}, 32'd1);
      check($sformatf("v%0d_cmd_ovr", i), {31'd0, cmd_ovr_a}, {31'd0, vecs[i].exp_ovr});
      tick();
      check($sformatf("v%0d_cmd_ovr_low", i), {31'd0, cmd_ovr_a}, 32'd0);
    end
    check("clr_rx_rdy_pulses_a", n_clr_a, 10);

    // ---- response serialisation on dut_a ----
    trmt_a = 1'b1;
    resp_a = 16'hC0DE;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hDE);
    tick();
    trmt_a = 1'b0;
    check("trmt_latency_uart_trmt", {31'd0, uart_trmt_a}, 32'd1);
    check("tx_busy_set", {31'd0, tx_busy_a}, 32'd1);
    tick();
    trmt_a = 1'b1;               // ignored while busy
    resp_a = 16'h1234;
    tick();
    trmt_a = 1'b0;
    wait_tx_done_a(0);
    tick();
    check("tx_busy_clear", {31'd0, tx_busy_a}, 32'd0);
    check("uart_trmt_count", n_trmt_a, 2);
    check("tx_done_count", n_txdone_a, 1);
    check("tx_exp_q_empty", exp_q.size(), 0);

    // ---- timeout on dut_b (limit 100 cycles) ----
    send_byte_b(8'h11);
    repeat (150) tick();
    send_byte_b(8'h22);
    send_byte_b(8'h33);
    send_byte_b(8'h44);
    check("tmo_frame_err_count", n_ferr_b, 1);
    check("tmo_cmd_b", {8'd0, cmd_b}, 32'h223344);
    check("tmo_cmd_rdy_b", {31'd0, cmd_rdy_b}, 32'd1);

    // 100 cycles between bytes is still within the limit.
    send_byte_b(8'h55);
    repeat (99) tick();
    send_byte_b(8'h66);
    send_byte_b(8'h77);
    check("tmo_edge_ok_err_count", n_ferr_b, 1);
    check("tmo_edge_ok_cmd_b", {8'd0, cmd_b}, 32'h556677);

    // A byte arriving in the timeout cycle starts a new frame.
    send_byte_b(8'h01);
    repeat (100) tick();
    send_byte_b(8'h02);
    send_byte_b(8'h03);
    send_byte_b(8'h04);
    check("tmo_cycle_err_count", n_ferr_b, 2);
    check("tmo_cycle_cmd_b", {8'd0, cmd_b}, 32'h020304);

    // ---- reset mid-frame and mid-transmit ----
    trmt_a = 1'b1;
    resp_a = 16'hC0DE;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hDE);
    tick();
    trmt_a = 1'b0;
    tick();
    send_byte_a(8'hAA, 1'b0);
    rx_rdy_a = 1'b1;
    rx_data_a = 8'hBB;
    rst_n = 1'b0;
    #1;
    check("mrst_cmd_a", {16'd0, cmd_a}, 32'd0);
    check("mrst_cmd_rdy_a", {31'd0, cmd_rdy_a}, 32'd0);
    check("mrst_clr_rx_rdy_a", {31'd0, clr_rx_rdy_a}, 32'd0);
    check("mrst_tx_busy_a", {31'd0, tx_busy_a}, 32'd0);
    check("mrst_uart_trmt_a", {31'd0, uart_trmt_a}, 32'd0);
    check("mrst_uart_tx_data_a", {24'd0, uart_tx_data_a}, 32'd0);
    check("mrst_cmd_b", {8'd0, cmd_b}, 32'd0);
    check("mrst_cmd_rdy_b", {31'd0, cmd_rdy_b}, 32'd0);
    exp_q.delete();              // the pending second byte is lost
    rx_rdy_a = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    trmt_before = n_trmt_a;
    send_byte_a(8'h12, 1'b0);
    send_byte_a(8'h34, 1'b0);
    check("post_rst_cmd_a", {16'd0, cmd_a}, 32'h1234);
    check("post_rst_cmd_rdy_a", {31'd0, cmd_rdy_a}, 32'd1);
    check("post_rst_cmd_ovr_a", {31'd0, cmd_ovr_a}, 32'd0);
    repeat (60) tick();
    check("post_rst_no_stray_trmt", n_trmt_a, trmt_before);

    // TX works again after reset.
    trmt_a = 1'b1;
    resp_a = 16'hBEAD;
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD);
    tick();
    trmt_a = 1'b0;
    wait_tx_done_a(n_txdone_a);
    check("post_rst_trmt_count", n_trmt_a, trmt_before + 2);
    check("post_rst_exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
